// File: rtl/regfile_mp.sv
// Multi-ported architectural register file with a per-register busy scoreboard,
// optional same-cycle write-to-read bypass and a sequenced clear after reset.
module regfile_mp #(
  parameter int NREAD  = 4,
  parameter int NWRITE = 2,
  parameter int NREG   = 32,
  parameter int WIDTH  = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    ready,
  input  logic [NREAD*AW-1:0]     raddr,
  output logic [NREAD*WIDTH-1:0]  rdata,
  output logic [NREAD-1:0]        rbusy,
  input  logic [NWRITE-1:0]       mark_vld,
  input  logic [NWRITE*AW-1:0]    mark_addr,
  input  logic [NWRITE-1:0]       we,
  input  logic [NWRITE*AW-1:0]    waddr,
  input  logic [NWRITE*WIDTH-1:0] wdata,
  output logic                    dbg_state
);

  // Handshake: none. Every read, mark and write port is accepted on every cycle
  // while ready=1; while ready=0 marks and writes are ignored and reads return 0.

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    clr_ptr;
  logic [WIDTH-1:0] rf [NREG];
  logic [NREG-1:0]  busy;

  assign ready     = (state_q == RUN);
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && clr_ptr == LAST) state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_ptr <= clr_ptr + AW'(1);
    end
  end

  // Later write ports overwrite earlier ones, so the youngest instruction wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        rf[clr_ptr] <= '0;
      end else begin
        for (int j = 0; j < NWRITE; j++) begin
          if (we[j] && waddr[j*AW +: AW] != '0)
            rf[waddr[j*AW +: AW]] <= wdata[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Marks are applied after write clears: a newly issued producer keeps the register busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (state_q == RUN) begin
      for (int j = 0; j < NWRITE; j++) begin
        if (we[j] && waddr[j*AW +: AW] != '0)
          busy[waddr[j*AW +: AW]] <= 1'b0;
      end
      for (int j = 0; j < NWRITE; j++) begin
        if (mark_vld[j] && mark_addr[j*AW +: AW] != '0)
          busy[mark_addr[j*AW +: AW]] <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      logic [AW-1:0]    ra;
      logic [WIDTH-1:0] d;
      logic             b;
      logic             hit;
      logic             mhit;
      ra   = raddr[i*AW +: AW];
      d    = rf[ra];
      b    = busy[ra];
      hit  = 1'b0;
      mhit = 1'b0;
      if (BYPASS != 0) begin
        for (int j = 0; j < NWRITE; j++) begin
          if (we[j] && waddr[j*AW +: AW] == ra) begin
            d   = wdata[j*WIDTH +: WIDTH];
            hit = 1'b1;
          end
          if (mark_vld[j] && mark_addr[j*AW +: AW] == ra) mhit = 1'b1;
        end
      end
      if (hit && !mhit) b = 1'b0;
      if (ra == '0 || state_q != RUN) begin
        d = '0;
        b = 1'b0;
      end
      rdata[i*WIDTH +: WIDTH] = d;
      rbusy[i]                = b;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance
// share all stimulus; expected values are hand-computed per step.
module tb_regfile_mp;

  localparam int NR = 4;
  localparam int NW = 2;
  localparam int AW = 5;
  localparam int W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR*AW-1:0]  raddr = '0;
  logic [NW-1:0]     mark_vld = '0;
  logic [NW*AW-1:0]  mark_addr = '0;
  logic [NW-1:0]     we = '0;
  logic [NW*AW-1:0]  waddr = '0;
  logic [NW*W-1:0]   wdata = '0;

  logic              ready, ready_nb;
  logic [NR*W-1:0]   rdata, rdata_nb;
  logic [NR-1:0]     rbusy, rbusy_nb;
  logic              dbg_state, dbg_state_nb;

  int checks = 0;
  int errors = 0;
  int n;

  regfile_mp #(.BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .ready(ready), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .mark_vld(mark_vld), .mark_addr(mark_addr), .we(we), .waddr(waddr), .wdata(wdata),
    .dbg_state(dbg_state)
  );

  regfile_mp #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .ready(ready_nb), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .mark_vld(mark_vld), .mark_addr(mark_addr), .we(we), .waddr(waddr), .wdata(wdata),
    .dbg_state(dbg_state_nb)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 2 time units after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ra(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] d);
    we[p]            = 1'b1;
    waddr[p*AW +: AW] = a;
    wdata[p*W +: W]   = d;
  endtask

  task automatic mk(input int p, input logic [AW-1:0] a);
    mark_vld[p]           = 1'b1;
    mark_addr[p*AW +: AW] = a;
  endtask

  task automatic idle();
    we       = '0;
    mark_vld = '0;
  endtask

  function automatic logic [W-1:0] rd(input int p);
    return rdata[p*W +: W];
  endfunction

  function automatic logic [W-1:0] rd_nb(input int p);
    return rdata_nb[p*W +: W];
  endfunction

  // Counts clock edges until ready rises, capped so a stuck clear cannot hang the run.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 100) begin
      cyc();
      cnt++;
    end
  endtask

  initial begin
    // Reset, with writes and marks to r6 held through the whole clear.
    #2;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wr(0, 5'd6, 32'h0000_BEEF);
    mk(1, 5'd6);
    set_ra(0, 5'd6);
    #1;
    check("ready_low_after_rst", {31'd0, ready}, 32'd0);
    check("state_clear", {31'd0, dbg_state}, 32'd0);
    check("rdata_zero_not_ready", rd(0), 32'd0);
    check("rbusy_zero_not_ready", {28'd0, rbusy}, 32'd0);
    wait_ready(n);
    idle();
    #1;
    check("clear_cycles", n, 32'd32);
    check("ready_high", {31'd0, ready}, 32'd1);
    check("ready_nb_high", {31'd0, ready_nb}, 32'd1);
    check("r6_write_ignored", rd(0), 32'd0);
    check("r6_mark_ignored", {31'd0, rbusy[0]}, 32'd0);
    for (int r = 0; r < 32; r += NR) begin
      for (int p = 0; p < NR; p++) set_ra(p, AW'(r + p));
      #1;
      for (int p = 0; p < NR; p++) check($sformatf("clr_r%0d", r + p), rd(p), 32'd0);
      check($sformatf("clr_busy_r%0d", r), {28'd0, rbusy}, 32'd0);
    end

    // Preload r5, then restart the clear in its 10th cycle.
    wr(0, 5'd5, 32'h0000_DEAD);
    cyc();
    idle();
    set_ra(0, 5'd5);
    #1;
    check("r5_preload", rd(0), 32'h0000_DEAD);
    check("r5_preload_nb", rd_nb(0), 32'h0000_DEAD);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wait_ready(n);
    #1;
    check("clear_restart_cycles", n, 32'd32);
    check("r5_cleared", rd(0), 32'd0);
    check("r5_cleared_nb", rd_nb(0), 32'd0);

    // Basic write then read on every port.
    wr(0, 5'd3, 32'h1234_5678);
    cyc();
    idle();
    for (int p = 0; p < NR; p++) set_ra(p, 5'd3);
    #1;
    for (int p = 0; p < NR; p++) check($sformatf("r3_port%0d", p), rd(p), 32'h1234_5678);
    check("r3_nb", rd_nb(2), 32'h1234_5678);

    // Register 0 ignores writes and is never bypassed.
    wr(0, 5'd0, 32'hFFFF_FFFF);
    set_ra(0, 5'd0);
    #1;
    check("r0_no_bypass", rd(0), 32'd0);
    cyc();
    idle();
    #1;
    check("r0_after_write", rd(0), 32'd0);

    // Two ports write r7 together: port 1 wins, also on the bypass path.
    wr(0, 5'd7, 32'h0000_1111);
    wr(1, 5'd7, 32'h0000_2222);
    set_ra(0, 5'd7);
    #1;
    check("r7_bypass_prio", rd(0), 32'h0000_2222);
    check("r7_nb_old", rd_nb(0), 32'd0);
    cyc();
    idle();
    #1;
    check("r7_prio", rd(0), 32'h0000_2222);
    check("r7_prio_nb", rd_nb(0), 32'h0000_2222);

    // Bypass on versus off for a same-cycle write/read of r9.
    wr(0, 5'd9, 32'h0000_00AA);
    set_ra(1, 5'd9);
    #1;
    check("r9_bypass", rd(1), 32'h0000_00AA);
    check("r9_nb_old", rd_nb(1), 32'd0);
    cyc();
    idle();
    #1;
    check("r9_nb_new", rd_nb(1), 32'h0000_00AA);

    // Scoreboard on r4.
    mk(0, 5'd4);
    set_ra(2, 5'd4);
    #1;
    check("r4_busy_same_cycle", {31'd0, rbusy[2]}, 32'd0);
    cyc();
    idle();
    #1;
    check("r4_busy_after_mark", {31'd0, rbusy[2]}, 32'd1);
    check("r4_busy_after_mark_nb", {31'd0, rbusy_nb[2]}, 32'd1);
    wr(0, 5'd4, 32'h0000_0055);
    #1;
    check("r4_wb_bypass_busy", {31'd0, rbusy[2]}, 32'd0);
    check("r4_wb_bypass_data", rd(2), 32'h0000_0055);
    check("r4_wb_nb_busy", {31'd0, rbusy_nb[2]}, 32'd1);
    cyc();
    idle();
    #1;
    check("r4_busy_cleared", {31'd0, rbusy[2]}, 32'd0);
    check("r4_busy_cleared_nb", {31'd0, rbusy_nb[2]}, 32'd0);
    check("r4_data", rd(2), 32'h0000_0055);

    // Mark and write r4 in one cycle while already busy: the mark keeps it busy.
    mk(0, 5'd4);
    cyc();
    idle();
    wr(0, 5'd4, 32'h0000_0066);
    mk(1, 5'd4);
    #1;
    check("r4_mark_wr_busy_same", {31'd0, rbusy[2]}, 32'd1);
    check("r4_mark_wr_data_same", rd(2), 32'h0000_0066);
    cyc();
    idle();
    #1;
    check("r4_mark_wr_busy", {31'd0, rbusy[2]}, 32'd1);
    check("r4_mark_wr_data", rd(2), 32'h0000_0066);

    // Marks to r0 never make it busy.
    mk(1, 5'd0);
    set_ra(3, 5'd0);
    cyc();
    idle();
    #1;
    check("r0_never_busy", {31'd0, rbusy[3]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
